// File: rtl/phase_acc_scheduler.sv
// Time-multiplexes one external adder across NUM_VOICES phase accumulators, one voice per cycle per tick.
// Optional PHASE_SYNC_EN adds a phase_sync input that zeroes all phases and aborts a running frame.
module phase_acc_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_VOICES = 4,
  localparam int AW = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  tick,
  input  logic                  fcw_we,
  input  logic [AW-1:0]         fcw_addr,
  input  logic [DATA_WIDTH-1:0] fcw_data,
  input  logic                  overrun_clr,
`ifdef PHASE_SYNC_EN
  input  logic                  phase_sync,
`endif
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH-1:0] add_sum,
  output logic [DATA_WIDTH-1:0] phase_out,
  output logic [AW-1:0]         phase_voice,
  output logic                  phase_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   fcw_reg   [NUM_VOICES];
  logic [DATA_WIDTH-1:0]   phase_reg [NUM_VOICES];
  logic [NUM_VOICES-1:0]   fcw_hit;
  logic [NUM_VOICES-1:0]   phase_hit;
  logic                    sync_req;
  logic                    run;
  logic                    last;
  logic                    emit;

`ifdef PHASE_SYNC_EN
  assign sync_req = phase_sync;
`else
  assign sync_req = 1'b0;
`endif

  assign run  = (state_reg == RUN);
  assign last = (cnt_reg == AW'(NUM_VOICES - 1));
  assign emit = run && !sync_req;
  assign busy = run;

  // Per-voice decode; addresses beyond NUM_VOICES-1 match no voice and are dropped.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign fcw_hit[gi]   = fcw_we && (fcw_addr == AW'(gi));
      assign phase_hit[gi] = run && (cnt_reg == AW'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    add_a      = '0;
    add_b      = '0;
    case (state_reg)
      IDLE: begin
        if (!sync_req && tick && enable) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        add_a = phase_reg[cnt_reg];
        add_b = fcw_reg[cnt_reg];
        if (sync_req || last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A write landing on the voice being summed only affects the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) fcw_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (fcw_hit[i]) fcw_reg[i] <= fcw_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_reg[i] <= '0;
    end else if (sync_req) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (phase_hit[i]) phase_reg[i] <= add_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_out   <= '0;
      phase_voice <= '0;
      phase_valid <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      phase_valid <= emit;
      frame_start <= emit && (cnt_reg == '0);
      if (emit) begin
        phase_out   <= add_sum;
        phase_voice <= cnt_reg;
      end
      // Setting beats a simultaneous clear.
      if (tick && run)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule
